// File: rtl/seg_chase_pkg.sv
// Shared types and constants for the segment-chase display controller.
package seg_chase_pkg;

    typedef enum logic [2:0] {
        SEG_A,
        SEG_B,
        SEG_C,
        SEG_D,
        SEG_E,
        SEG_F
    } seg_state_e;

    // Active-low segment drive, bit 6 = a ... bit 0 = g
    localparam logic [6:0] PAT_A   = 7'b0111111;
    localparam logic [6:0] PAT_B   = 7'b1011111;
    localparam logic [6:0] PAT_C   = 7'b1101111;
    localparam logic [6:0] PAT_D   = 7'b1110111;
    localparam logic [6:0] PAT_E   = 7'b1111011;
    localparam logic [6:0] PAT_F   = 7'b1111101;
    localparam logic [6:0] PAT_OFF = 7'b1111111;

    localparam logic [1:0] SPD_SLOW = 2'd0;
    localparam logic [1:0] SPD_MID  = 2'd1;
    localparam logic [1:0] SPD_FAST = 2'd2;

    localparam logic [3:0] ANODE_DIGIT0 = 4'b1110;

    function automatic logic [6:0] seg_pattern(input seg_state_e s);
        logic [6:0] p;
        case (s)
            SEG_A:   p = PAT_A;
            SEG_B:   p = PAT_B;
            SEG_C:   p = PAT_C;
            SEG_D:   p = PAT_D;
            SEG_E:   p = PAT_E;
            SEG_F:   p = PAT_F;
            default: p = PAT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_chase_ctrl_btn_conditioner.sv
// Raw button -> synchronized, debounced, one-cycle press pulse on each accepted 0->1 change.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            differ;

    always_comb begin
        differ  = sync_q[1] ^ level_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (differ) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
                // Only the accepted rising edge is a press; release is silent.
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/seg_chase_ctrl.sv
// Segment-chase animation controller: three conditioned buttons set speed/pause, one
// prescaler produces step ticks, a six-state FSM walks segments a..f on digit 0.
module seg_chase_ctrl
    import seg_chase_pkg::*;
#(
    parameter int unsigned DIV_SLOW  = 25_000_000,
    parameter int unsigned DIV_MID   = 12_500_000,
    parameter int unsigned DIV_FAST  = 6_250_000,
    parameter int unsigned DB_CYCLES = 500_000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_faster_i,
    input  logic       btn_slower_i,
    input  logic       btn_pause_i,
    output logic [6:0] disp_o,
    output logic [3:0] anode_o,
    output logic [1:0] speed_o,
    output logic       paused_o,
    output logic       tick_o
);

    logic press_faster, press_slower, press_pause;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_faster (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_faster_i),
        .press_o (press_faster)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_slower (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_slower_i),
        .press_o (press_slower)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_pause (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_pause_i),
        .press_o (press_pause)
    );

    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] div_last;
    seg_state_e       state_q, state_d;
    logic [6:0]       disp_q, disp_d;
    logic             tick;
    logic             spd_change;

    always_comb begin
        case (speed_q)
            SPD_MID:  div_last = CNT_W'(DIV_MID - 1);
            SPD_FAST: div_last = CNT_W'(DIV_FAST - 1);
            default:  div_last = CNT_W'(DIV_SLOW - 1);
        endcase
    end

    assign tick = !paused_q && (presc_q == div_last);

    always_comb begin
        speed_d = speed_q;
        if (press_faster && !press_slower && speed_q != SPD_FAST) begin
            speed_d = speed_q + 2'd1;
        end else if (press_slower && !press_faster && speed_q != SPD_SLOW) begin
            speed_d = speed_q - 2'd1;
        end
        spd_change = (speed_d != speed_q);
        paused_d   = paused_q ^ press_pause;

        // A real speed change restarts the period even while paused.
        if (spd_change) begin
            presc_d = '0;
        end else if (paused_q) begin
            presc_d = presc_q;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SEG_A:   state_d = SEG_B;
                SEG_B:   state_d = SEG_C;
                SEG_C:   state_d = SEG_D;
                SEG_D:   state_d = SEG_E;
                SEG_E:   state_d = SEG_F;
                default: state_d = SEG_A;
            endcase
        end
        disp_d = seg_pattern(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            speed_q  <= SPD_SLOW;
            paused_q <= 1'b0;
            presc_q  <= '0;
            state_q  <= SEG_A;
            disp_q   <= PAT_A;
        end else begin
            speed_q  <= speed_d;
            paused_q <= paused_d;
            presc_q  <= presc_d;
            state_q  <= state_d;
            disp_q   <= disp_d;
        end
    end

    assign disp_o   = disp_q;
    assign anode_o  = ANODE_DIGIT0;
    assign speed_o  = speed_q;
    assign paused_o = paused_q;
    assign tick_o   = tick;

endmodule

// File: tb/tb_seg_chase_ctrl.sv
// Directed bench for seg_chase_ctrl with shortened dividers (8/4/2) and 4-cycle debounce.
module tb_seg_chase_ctrl;

    localparam int unsigned DivSlow  = 8;
    localparam int unsigned DivMid   = 4;
    localparam int unsigned DivFast  = 2;
    localparam int unsigned DbCycles = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bf, bs, bp;
    logic [6:0] disp;
    logic [3:0] anode;
    logic [1:0] speed;
    logic       paused;
    logic       tick;

    int errors = 0;
    int checks = 0;
    int tick_count = 0;
    int n;
    int base;
    int t0;
    int guard;

    logic [6:0] pats [6] = '{7'b0111111, 7'b1011111, 7'b1101111,
                             7'b1110111, 7'b1111011, 7'b1111101};

    always #5 clk = ~clk;

    always @(negedge clk) if (tick === 1'b1) tick_count++;

    seg_chase_ctrl #(
        .DIV_SLOW  (DivSlow),
        .DIV_MID   (DivMid),
        .DIV_FAST  (DivFast),
        .DB_CYCLES (DbCycles),
        .CNT_W     (25)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_faster_i (bf),
        .btn_slower_i (bs),
        .btn_pause_i  (bp),
        .disp_o       (disp),
        .anode_o      (anode),
        .speed_o      (speed),
        .paused_o     (paused),
        .tick_o       (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Call from the first cycle of a period; returns that period's length in cycles.
    task automatic count_to_tick(output int len);
        len = 1;
        while (tick !== 1'b1 && len < 64) begin
            step(1);
            len++;
        end
    endtask

    task automatic release_all();
        bf = 1'b0;
        bs = 1'b0;
        bp = 1'b0;
        step(8);
    endtask

    task automatic check_disp_model(input string tag);
        check(tag, {25'd0, disp}, {25'd0, pats[(tick_count - base) % 6]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bf = 1'b0;
        bs = 1'b0;
        bp = 1'b0;
        step(3);
        check("rst_disp", {25'd0, disp}, 32'h3f);
        check("rst_anode", {28'd0, anode}, 32'he);
        check("rst_speed", {30'd0, speed}, 32'd0);
        check("rst_paused", {31'd0, paused}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;
        base = tick_count;

        // Free-running chase at speed 0
        for (int k = 1; k <= 6; k++) begin
            count_to_tick(n);
            check("t1_gap", n, 8);
            step(1);
            check("t1_disp", {25'd0, disp}, {25'd0, pats[k % 6]});
            check("t1_anode", {28'd0, anode}, 32'he);
        end

        // Faster presses 0->1->2 then saturate
        bf = 1'b1;
        step(7);
        check("t2_speed1", {30'd0, speed}, 32'd1);
        count_to_tick(n);
        check("t2_gap_mid_first", n, 4);
        step(1);
        count_to_tick(n);
        check("t2_gap_mid", n, 4);
        release_all();
        check("t2_speed1_hold", {30'd0, speed}, 32'd1);
        bf = 1'b1;
        step(7);
        check("t2_speed2", {30'd0, speed}, 32'd2);
        count_to_tick(n);
        check("t2_gap_fast", n, 2);
        release_all();
        bf = 1'b1;
        step(7);
        check("t2_speed_sat", {30'd0, speed}, 32'd2);
        release_all();
        check("t2_speed_sat_hold", {30'd0, speed}, 32'd2);
        check_disp_model("t2_disp_model");

        // Short glitch ignored, then slower down to 0, then saturated press keeps phase
        bs = 1'b1;
        step(2);
        bs = 1'b0;
        step(10);
        check("t3_glitch", {30'd0, speed}, 32'd2);
        bs = 1'b1;
        step(7);
        check("t3_speed1", {30'd0, speed}, 32'd1);
        release_all();
        bs = 1'b1;
        step(7);
        check("t3_speed0", {30'd0, speed}, 32'd0);
        count_to_tick(n);
        check("t3_gap_slow", n, 8);
        release_all();
        count_to_tick(n);
        step(1);
        bs = 1'b1;
        count_to_tick(n);
        check("t3_sat_no_clear", n, 8);
        check("t3_speed_sat", {30'd0, speed}, 32'd0);
        release_all();

        // Simultaneous faster+slower at speed 1
        bf = 1'b1;
        step(7);
        check("t4_speed1", {30'd0, speed}, 32'd1);
        release_all();
        count_to_tick(n);
        step(1);
        bf = 1'b1;
        bs = 1'b1;
        count_to_tick(n);
        check("t4_gap_a", n, 4);
        step(1);
        count_to_tick(n);
        check("t4_gap_b", n, 4);
        step(1);
        count_to_tick(n);
        check("t4_gap_c", n, 4);
        check("t4_speed", {30'd0, speed}, 32'd1);
        release_all();
        check("t4_speed_after", {30'd0, speed}, 32'd1);

        // Pause mid-period, change speed while paused, resume
        count_to_tick(n);
        step(1);
        step(2);
        bp = 1'b1;
        step(7);
        check("t5_paused", {31'd0, paused}, 32'd1);
        check("t5_presc_held", dut.presc_q, 32'd1);
        check_disp_model("t5_disp_frozen");
        t0 = tick_count;
        release_all();
        check("t5_no_ticks", tick_count - t0, 32'd0);
        check("t5_presc_still", dut.presc_q, 32'd1);
        check("t5_tick_low", {31'd0, tick}, 32'd0);
        check_disp_model("t5_disp_still");
        bf = 1'b1;
        step(7);
        check("t5_speed2", {30'd0, speed}, 32'd2);
        check("t5_still_paused", {31'd0, paused}, 32'd1);
        check("t5_presc_clr", dut.presc_q, 32'd0);
        release_all();
        bp = 1'b1;
        step(7);
        check("t5_unpaused", {31'd0, paused}, 32'd0);
        check("t5_no_ticks_total", tick_count - t0, 32'd0);
        count_to_tick(n);
        check("t5_resume_gap", n, 2);
        release_all();

        // Asynchronous reset at state D
        guard = 0;
        while (disp !== 7'b1110111 && guard < 64) begin
            step(1);
            guard++;
        end
        check("t6_reach_d", {25'd0, disp}, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_disp", {25'd0, disp}, 32'h3f);
        check("t6_speed", {30'd0, speed}, 32'd0);
        check("t6_paused", {31'd0, paused}, 32'd0);
        check("t6_tick", {31'd0, tick}, 32'd0);
        check("t6_anode", {28'd0, anode}, 32'he);
        step(2);
        rst_n = 1'b1;
        count_to_tick(n);
        check("t6_first_gap", n, 8);
        step(1);
        check("t6_disp_b", {25'd0, disp}, 32'h5f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
